// File: rtl/rf_cfg_pkg.sv
// Shared definitions for the RF module configuration decoder.
// Readback (C1/C3) support is selected with the RF_CFG_READBACK_EN macro.
package rf_cfg_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StParam,
        StTriple,
        StResp
    } rf_state_e;

    localparam logic [7:0] HdrC0 = 8'hC0;
    localparam logic [7:0] HdrC1 = 8'hC1;
    localparam logic [7:0] HdrC2 = 8'hC2;
    localparam logic [7:0] HdrC3 = 8'hC3;
    localparam logic [7:0] HdrC4 = 8'hC4;

    localparam int unsigned CfgBytes = 5;

    // Bit offsets of each field inside the 40-bit configuration word.
    localparam int unsigned OptionLsb = 0;
    localparam int unsigned ChanLsb   = 8;
    localparam int unsigned SpedLsb   = 16;
    localparam int unsigned AddlLsb   = 24;
    localparam int unsigned AddhLsb   = 32;

    localparam logic [39:0] DefaultCfg = 40'h00_00_1A_17_44;

    function automatic logic is_param_hdr(input logic [7:0] b);
        return (b == HdrC0) || (b == HdrC2);
    endfunction

endpackage

// File: rtl/rf_cfg_timeout.sv
// Inter-byte timeout: reloads on every accepted byte, strobes expire_o after
// TIMEOUT_CYCLES consecutive enabled cycles without a reload.
module rf_cfg_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] LoadVal = CntW'(TIMEOUT_CYCLES);

    logic [CntW-1:0] cnt_q;

    assign expire_o = enable_i && !load_i && (cnt_q == CntW'(1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= LoadVal;
        end else if (!enable_i) begin
            cnt_q <= '0;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CntW'(1);
        end
    end

endmodule

// File: rtl/rf_config_decoder.sv
// Sleep-mode command decoder for the RF module configuration (C0..C4 commands).
// Define RF_CFG_READBACK_EN to build the C1/C3 readback response path.
module rf_config_decoder
    import rf_cfg_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter logic [39:0] DEFAULT_CFG    = DefaultCfg,
    parameter logic [23:0] VERSION_WORD   = 24'h32_0D_14
) (
    input  logic                  internal_clk,
    input  logic                  rst,
    input  logic                  mode_sleep,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    input  logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_use,
    output logic [39:0]           cfg_word,
    output logic                  cfg_save,
    output logic                  cfg_update,
    output logic                  soft_reset,
    output logic                  busy
);

    rf_state_e   state_q;
    logic [2:0]  idx_q;
    logic [1:0]  match_q;
    logic [7:0]  hdr_q;
    logic        save_pend_q;
    logic [31:0] shadow_q;
    logic [39:0] cfg_word_q;
    logic        cfg_save_q;
    logic        cfg_update_q;
    logic        soft_reset_q;

    logic [7:0]  rx_byte;
    logic        rx_take;
    logic        in_cmd;
    logic        hdr_trip;
    logic        tmo_expire;

    assign rx_byte = rx_data[7:0];
    assign rx_take = rx_valid && mode_sleep && (state_q != StResp);
    assign in_cmd  = mode_sleep && ((state_q == StParam) || (state_q == StTriple));

`ifdef RF_CFG_READBACK_EN
    assign hdr_trip = (rx_byte == HdrC4) || (rx_byte == HdrC1) || (rx_byte == HdrC3);

    logic [47:0] resp_q;
    logic [2:0]  resp_left_q;
    logic        tx_fire;

    assign tx_fire = (state_q == StResp) && tx_ready && mode_sleep;
    assign tx_use  = tx_fire;
    assign tx_data = tx_fire ? DATA_WIDTH'(resp_q[47:40]) : '0;
`else
    assign hdr_trip = (rx_byte == HdrC4);
    assign tx_use   = 1'b0;
    assign tx_data  = '0;

    logic unused_readback;
    assign unused_readback = tx_ready ^ (^VERSION_WORD);
`endif

    assign cfg_word   = cfg_word_q;
    assign cfg_save   = cfg_save_q;
    assign cfg_update = cfg_update_q;
    assign soft_reset = soft_reset_q;
    assign busy       = (state_q != StIdle);

    rf_cfg_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i   (internal_clk),
        .rst_i   (rst),
        .load_i  (rx_take),
        .enable_i(in_cmd),
        .expire_o(tmo_expire)
    );

    always_ff @(posedge internal_clk) begin
        if (rst) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            match_q      <= '0;
            hdr_q        <= '0;
            save_pend_q  <= 1'b0;
            shadow_q     <= '0;
            cfg_word_q   <= DEFAULT_CFG;
            cfg_save_q   <= 1'b0;
            cfg_update_q <= 1'b0;
            soft_reset_q <= 1'b0;
`ifdef RF_CFG_READBACK_EN
            resp_q       <= '0;
            resp_left_q  <= '0;
`endif
        end else begin
            cfg_update_q <= 1'b0;
            soft_reset_q <= 1'b0;
            if (!mode_sleep) begin
                state_q <= StIdle;
                idx_q   <= '0;
                match_q <= '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (rx_valid) begin
                            if (is_param_hdr(rx_byte)) begin
                                state_q     <= StParam;
                                idx_q       <= '0;
                                save_pend_q <= (rx_byte == HdrC0);
                            end else if (hdr_trip) begin
                                state_q <= StTriple;
                                hdr_q   <= rx_byte;
                                match_q <= 2'd1;
                            end
                        end
                    end
                    StParam: begin
                        // The live word is written only once all five bytes are in.
                        if (rx_valid) begin
                            if (idx_q == 3'(CfgBytes - 1)) begin
                                cfg_word_q   <= {shadow_q, rx_byte};
                                cfg_save_q   <= save_pend_q;
                                cfg_update_q <= 1'b1;
                                state_q      <= StIdle;
                                idx_q        <= '0;
                            end else begin
                                shadow_q <= {shadow_q[23:0], rx_byte};
                                idx_q    <= idx_q + 3'd1;
                            end
                        end else if (tmo_expire) begin
                            state_q <= StIdle;
                            idx_q   <= '0;
                        end
                    end
                    StTriple: begin
                        if (rx_valid) begin
                            if (rx_byte != hdr_q) begin
                                state_q <= StIdle;
                                match_q <= '0;
                            end else if (match_q == 2'd2) begin
                                match_q <= '0;
                                state_q <= StIdle;
                                if (hdr_q == HdrC4) begin
                                    soft_reset_q <= 1'b1;
`ifdef RF_CFG_READBACK_EN
                                end else if (hdr_q == HdrC1) begin
                                    state_q     <= StResp;
                                    resp_q      <= {HdrC0, cfg_word_q};
                                    resp_left_q <= 3'd6;
                                end else begin
                                    state_q     <= StResp;
                                    resp_q      <= {HdrC3, VERSION_WORD, 16'h0000};
                                    resp_left_q <= 3'd4;
`endif
                                end
                            end else begin
                                match_q <= match_q + 2'd1;
                            end
                        end else if (tmo_expire) begin
                            state_q <= StIdle;
                            match_q <= '0;
                        end
                    end
                    StResp: begin
`ifdef RF_CFG_READBACK_EN
                        if (tx_ready) begin
                            resp_q      <= {resp_q[39:0], 8'h00};
                            resp_left_q <= resp_left_q - 3'd1;
                            if (resp_left_q == 3'd1) begin
                                state_q <= StIdle;
                            end
                        end
`else
                        state_q <= StIdle;
`endif
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rf_config_decoder.sv
// Self-checking bench for rf_config_decoder: command-level model compared every cycle,
// plus literal expectations. Readback checks follow RF_CFG_READBACK_EN.
module tb_rf_config_decoder;

    localparam int unsigned Tmo = 20;
`ifdef RF_CFG_READBACK_EN
    localparam bit Rb = 1'b1;
`else
    localparam bit Rb = 1'b0;
`endif

    logic        internal_clk = 1'b0;
    logic        rst, mode_sleep, rx_valid, tx_ready;
    logic [7:0]  rx_data, tx_data;
    logic        tx_use;
    logic [39:0] cfg_word;
    logic        cfg_save, cfg_update, soft_reset, busy;

    int checks = 0;
    int errors = 0;
    int n_upd  = 0;
    int n_sr   = 0;
    logic [7:0] txs[$];

    always #5 internal_clk = ~internal_clk;

    rf_config_decoder #(
        .TIMEOUT_CYCLES(Tmo)
    ) dut (
        .internal_clk(internal_clk),
        .rst         (rst),
        .mode_sleep  (mode_sleep),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_ready    (tx_ready),
        .tx_data     (tx_data),
        .tx_use      (tx_use),
        .cfg_word    (cfg_word),
        .cfg_save    (cfg_save),
        .cfg_update  (cfg_update),
        .soft_reset  (soft_reset),
        .busy        (busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Command-level model: bytes of the open command, pending reply bytes, configuration.
    logic [7:0]  cmd[$];
    logic [7:0]  txq[$];
    int          idle_cnt;
    logic [39:0] m_cfg;
    logic        m_save, m_upd, m_sr;
    bit          started = 1'b0;

    function automatic bit is_trip(input logic [7:0] b);
        return (b == 8'hC4) || (Rb && ((b == 8'hC1) || (b == 8'hC3)));
    endfunction

    always @(posedge internal_clk) begin
        logic [7:0] h;
        started = 1'b1;
        m_upd   = 1'b0;
        m_sr    = 1'b0;
        if (rst) begin
            m_cfg  = 40'h00_00_1A_17_44;
            m_save = 1'b0;
            cmd.delete();
            txq.delete();
            idle_cnt = 0;
        end else if (!mode_sleep) begin
            cmd.delete();
            txq.delete();
            idle_cnt = 0;
        end else if (txq.size() > 0) begin
            if (tx_ready) void'(txq.pop_front());
        end else if (rx_valid) begin
            cmd.push_back(rx_data);
            idle_cnt = 0;
            h = cmd[0];
            if (h == 8'hC0 || h == 8'hC2) begin
                if (cmd.size() == 6) begin
                    m_cfg  = {cmd[1], cmd[2], cmd[3], cmd[4], cmd[5]};
                    m_save = (h == 8'hC0);
                    m_upd  = 1'b1;
                    cmd.delete();
                end
            end else if (is_trip(h)) begin
                if (cmd[cmd.size()-1] != h) begin
                    cmd.delete();
                end else if (cmd.size() == 3) begin
                    if (h == 8'hC4) begin
                        m_sr = 1'b1;
                    end else if (h == 8'hC1) begin
                        txq.push_back(8'hC0);
                        for (int i = 4; i >= 0; i--) txq.push_back(m_cfg[8*i +: 8]);
                    end else begin
                        txq.push_back(8'hC3);
                        txq.push_back(8'h32);
                        txq.push_back(8'h0D);
                        txq.push_back(8'h14);
                    end
                    cmd.delete();
                end
            end else begin
                cmd.delete();
            end
        end else if (cmd.size() > 0) begin
            idle_cnt++;
            if (idle_cnt >= Tmo) begin
                cmd.delete();
                idle_cnt = 0;
            end
        end
    end

    always @(negedge internal_clk) begin
        logic       exp_use;
        logic [7:0] exp_data;
        if (started) begin
            exp_use  = mode_sleep && tx_ready && (txq.size() != 0);
            exp_data = exp_use ? txq[0] : 8'h00;
            chk("cfg_word", cfg_word, m_cfg);
            chk("cfg_save", cfg_save, m_save);
            chk("cfg_update", cfg_update, m_upd);
            chk("soft_reset", soft_reset, m_sr);
            chk("busy", busy, (cmd.size() != 0) || (txq.size() != 0));
            chk("tx_use", tx_use, exp_use);
            chk("tx_data", tx_data, exp_data);
            if (cfg_update) n_upd++;
            if (soft_reset) n_sr++;
            if (tx_use) txs.push_back(tx_data);
        end
    end

    task automatic tick();
        @(posedge internal_clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_bytes(input logic [47:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) send(w[8*i +: 8]);
    endtask

    task automatic drain(input bit toggle);
        for (int i = 0; i < 60 && busy; i++) begin
            if (toggle) tx_ready = ~tx_ready;
            tick();
        end
        tx_ready = 1'b1;
        chk("reply drained", busy, 1'b0);
    endtask

    function automatic logic [47:0] pack_txs();
        logic [47:0] g = '0;
        foreach (txs[i]) g = {g[39:0], txs[i]};
        return g;
    endfunction

    initial begin
        rst = 1'b1; mode_sleep = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset cfg_word", cfg_word, 40'h00_00_1A_17_44);
        chk("reset cfg_save", cfg_save, 1'b0);
        chk("reset busy", busy, 1'b0);

        n_upd = 0;
        send_bytes(48'hC0_27_02_FF_00_AA, 6);
        tick(); tick();
        chk("c0 cfg_word", cfg_word, 40'h27_02_FF_00_AA);
        chk("c0 cfg_save", cfg_save, 1'b1);
        chk("c0 update count", n_upd, 1);

        txs.delete();
        send_bytes(48'hC1_C1_C1, 3);
        if (Rb) begin
            drain(1'b1);
            chk("c1 length", txs.size(), 6);
            chk("c1 stream", pack_txs(), 48'hC0_27_02_FF_00_AA);

            txs.delete(); n_upd = 0; tx_ready = 1'b0;
            send_bytes(48'hC3_C3_C3, 3);
            tick(); tick();
            send(8'hC0);
            tx_ready = 1'b1;
            drain(1'b0);
            chk("c3 stream", pack_txs(), 48'h0000_C3_32_0D_14);
            chk("c3 no update", n_upd, 0);

            tx_ready = 1'b0;
            send_bytes(48'hC1_C1_C1, 3);
            tick();
            mode_sleep = 1'b0;
            tick();
            chk("sleep drops reply", busy, 1'b0);
            mode_sleep = 1'b1; tx_ready = 1'b1;
            tick();
            chk("dropped reply silent", tx_use, 1'b0);
        end else begin
            chk("c1 ignored", busy, 1'b0);
            repeat (3) tick();
            chk("c1 no reply", txs.size(), 0);
        end

        n_upd = 0;
        send_bytes(48'hC2_11_22, 3);
        mode_sleep = 1'b0;
        tick();
        send_bytes(48'h33_44_55, 3);
        chk("sleep abort busy", busy, 1'b0);
        mode_sleep = 1'b1;
        tick(); tick();
        chk("sleep abort cfg", cfg_word, 40'h27_02_FF_00_AA);
        chk("sleep abort no update", n_upd, 0);

        n_sr = 0;
        send_bytes(48'hC4_C4_C4, 3);
        tick(); tick();
        chk("c4 soft_reset count", n_sr, 1);
        chk("c4 cfg kept", cfg_word, 40'h27_02_FF_00_AA);
        n_sr = 0;
        send_bytes(48'hC4_C4_C3, 3);
        tick();
        chk("c4c4c3 no soft_reset", n_sr, 0);
        chk("c4c4c3 idle", busy, 1'b0);

        send(8'h55);
        chk("junk byte idle", busy, 1'b0);

        n_upd = 0;
        send_bytes(48'hC2_C0_C4_01_02_03, 6);
        tick(); tick();
        chk("c2 cfg_word", cfg_word, 40'hC0_C4_01_02_03);
        chk("c2 cfg_save", cfg_save, 1'b0);
        chk("c2 update count", n_upd, 1);

        send_bytes(48'hC0_11, 2);
        repeat (Tmo - 2) tick();
        chk("timeout not yet", busy, 1'b1);
        repeat (3) tick();
        chk("timeout idle", busy, 1'b0);
        send_bytes(48'hC0_01_02_03_04_05, 6);
        tick(); tick();
        chk("after timeout cfg", cfg_word, 40'h01_02_03_04_05);

        send_bytes(48'hC2_AA, 2);
        repeat (Tmo - 1) tick();
        send_bytes(48'hBB_CC_DD_EE, 4);
        tick(); tick();
        chk("restarted timeout cfg", cfg_word, 40'hAA_BB_CC_DD_EE);

        send_bytes(48'hC0_AA_BB, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        send_bytes(48'hCC_DD_EE, 3);
        tick();
        chk("mid-command reset cfg", cfg_word, 40'h00_00_1A_17_44);
        chk("mid-command reset busy", busy, 1'b0);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_config_decoder.md
RF_CONFIG_DECODER -- requirements
Module: rf_config_decoder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, UART byte width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000, inter-byte timeout in internal_clk cycles.
REQ-003 SHALL have parameter DEFAULT_CFG, default 40'h00_00_1A_17_44, reset value of {ADDH,ADDL,SPED,CHAN,OPTION}.
REQ-004 SHALL have parameter VERSION_WORD, default 24'h32_0D_14, bytes returned after C3 header.
REQ-005 internal_clk  in  1  single clock for all logic.
REQ-006 rst  in  1  synchronous reset, active-high.
REQ-007 mode_sleep  in  1  high when M0=M1=1; commands accepted only while high.
REQ-008 rx_data  in  DATA_WIDTH  byte from MCU-side UART receiver.
REQ-009 rx_valid  in  1  one-cycle strobe, rx_data valid.
REQ-010 tx_ready  in  1  MCU-side UART transmitter can accept a byte this cycle.
REQ-011 tx_data  out  DATA_WIDTH  response byte.
REQ-012 tx_use  out  1  one-cycle strobe, tx_data valid; asserted only when tx_ready=1.
REQ-013 cfg_word  out  40  current {ADDH,ADDL,SPED,CHAN,OPTION}.
REQ-014 cfg_save  out  1  1 = last write was C0 (persistent), 0 = C2 (volatile).
REQ-015 cfg_update  out  1  one-cycle pulse when cfg_word changes.
REQ-016 soft_reset  out  1  one-cycle pulse on valid C4 C4 C4.
REQ-017 busy  out  1  high from first accepted byte to end of command; drives AUX low.

Function
REQ-018 SHALL implement states IDLE, PARAM, TRIPLE, RESP.
REQ-019 IDLE: C0/C2 byte -> PARAM with index 0; C1/C3/C4 -> TRIPLE with match count 1; any other byte SHALL be discarded, stay IDLE.
REQ-020 PARAM: collect 5 bytes into shadow register; on 5th byte SHALL copy shadow to cfg_word, set cfg_save, pulse cfg_update next cycle, return IDLE.
REQ-021 cfg_word SHALL never hold partially written parameters.
REQ-022 TRIPLE: byte equal to header increments count; mismatch SHALL discard and return IDLE (mismatching byte not reinterpreted).
REQ-023 Count 3 for C4 SHALL pulse soft_reset and return IDLE; cfg_word unchanged.
REQ-024 Count 3 for C1 SHALL enter RESP sending C0 then 5 cfg_word bytes MSB first; for C3 sending C3 then 3 VERSION_WORD bytes MSB first.
REQ-025 RESP: one byte per cycle where tx_ready=1; tx_ready low stalls without loss; after last byte return IDLE.
REQ-026 rx_valid during RESP SHALL be ignored.
REQ-027 In PARAM/TRIPLE, TIMEOUT_CYCLES without rx_valid SHALL abort to IDLE, no side effects; counter restarts at each rx_valid.
REQ-028 mode_sleep low SHALL abort any state to IDLE within one cycle, no update, pending response dropped; rx_valid ignored while low.
REQ-029 busy SHALL be 0 exactly in IDLE.

Reset
REQ-030 On rst: state IDLE, cfg_word=DEFAULT_CFG, cfg_save=0, tx_data=0, tx_use=0, cfg_update=0, soft_reset=0, busy=0, counters 0.
REQ-031 rst mid-command SHALL discard all partial data.
REQ-032 soft_reset SHALL NOT reset this block.

Configuration
REQ-033 Macro RF_CFG_READBACK_EN: defined -> C1 and C3 handled per REQ-024; undefined -> C1/C3 treated as invalid headers in IDLE, RESP state and tx path not built, tx_use tied 0.

Structure
REQ-034 Shared package rf_cfg_pkg SHALL hold state enum, header constants (C0..C4), cfg field offsets, DEFAULT_CFG.
REQ-035 One sub-module rf_cfg_timeout (loadable down-counter, expiry strobe) SHALL implement REQ-027.

Verification
REQ-036 sleep, C0 27 02 FF 00 AA -> cfg_word=40'h2702FF00AA, cfg_save=1, one cfg_update pulse.
REQ-037 sleep, C2 11 22 then mode_sleep=0, then 33 44 55 -> cfg_word unchanged, no cfg_update, busy=0.
REQ-038 sleep, C4 C4 C4 -> one soft_reset pulse; C4 C4 C3 -> none, IDLE.
REQ-039 with macro, after REQ-036, C1 C1 C1 with tx_ready toggling 1/0 -> tx stream C0 27 02 FF 00 AA, no loss.
REQ-040 C0 11 then TIMEOUT_CYCLES idle -> IDLE, busy=0; following C0 plus 5 bytes accepted normally.
